b02_param: RTL and testbench
============================

Name: b02_param

Overview:
- Parametrised successor to the serial BCD-digit recogniser FSM. NCH independent channels each take a serial bit stream on LINEA.
- Each channel groups bits into DIGIT_W-bit digits, MSB-first or LSB-first. A completed digit whose value is < LIMIT produces a one-cycle U pulse; otherwise it produces an ERR pulse.
- Adds over the single-channel version: bit-enable gating, resynchronisation, a registered digit value and saturating hit counters.
- Sits in the benchmark suite as the scalable sequential recogniser.

Parameters:
- NCH, 2, number of independent channels (>=1)
- DIGIT_W, 4, bits per digit (2..8)
- LIMIT, 10, digit is valid iff value < LIMIT; 1 <= LIMIT <= 2**DIGIT_W
- CNT_W, 8, width of per-channel valid-digit counter

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- EN  in  NCH  per-channel bit-valid; LINEA[i] is sampled only when EN[i]=1
- LINEA  in  NCH  serial data bit per channel
- MODE  in  1  0 = MSB-first, 1 = LSB-first; must be stable while any channel is in COLLECT (change otherwise undefined)
- SYNC  in  NCH  per-channel realign: discard partial digit
- CLR  in  1  synchronous clear of all HIT_CNT
- U_REG  out  NCH  one-cycle pulse: valid digit completed
- ERR  out  NCH  one-cycle pulse: invalid digit (value >= LIMIT) completed
- DIGIT  out  NCH*DIGIT_W  last completed digit value, channel i at [i*DIGIT_W +: DIGIT_W]
- HIT_CNT  out  NCH*CNT_W  saturating count of valid digits per channel

Behaviour:
- Reset (reset=0, async): all channels go to IDLE; shift register and bit counter = 0; U_REG = 0, ERR = 0, DIGIT = 0, HIT_CNT = 0.
- Per-channel FSM, states IDLE and COLLECT; bit counter BC has range 0..DIGIT_W-1.
  - IDLE, EN=1: the bit is stored as bit 1 of the digit; BC = 1; go to COLLECT. If DIGIT_W would be reached (never, since DIGIT_W >= 2), no special case is needed.
  - COLLECT, EN=1, BC < DIGIT_W-1: store the bit; BC++.
  - COLLECT, EN=1, BC = DIGIT_W-1: the digit completes this cycle; return to IDLE; BC = 0.
  - EN=0: hold state and BC; no outputs.
- Bit placement:
  - MSB-first: shift left, new bit enters the LSB.
  - LSB-first: the new bit is placed at position BC.
- Completion is registered; latency is exactly 1 cycle. On the clock edge after the last bit is accepted:
  - DIGIT[i] <= assembled value;
  - U_REG[i] = (value < LIMIT) for exactly one cycle;
  - ERR[i] = (value >= LIMIT) for exactly one cycle.
- U_REG and ERR are never both 1, and never high for 2 consecutive cycles unless DIGIT_W consecutive... (impossible: DIGIT_W >= 2).
- Back-to-back digits: the first bit of the next digit is accepted in the cycle after completion, with no gap required.
- SYNC[i]=1: the channel goes to IDLE, BC = 0 and the partial digit is dropped; no U_REG/ERR is generated.
  - SYNC and EN in the same cycle: the sampled bit becomes bit 1 of a new digit (state COLLECT, BC = 1).
  - SYNC in the same cycle as a completing bit: SYNC wins; the digit is discarded and no pulse is generated.
- HIT_CNT[i] increments by 1 on each U_REG[i] pulse and saturates at 2**CNT_W-1 (no wrap).
  - CLR: all counters = 0. CLR wins over a simultaneous increment; U_REG still pulses.
- DIGIT holds its value until the next completion; it is unaffected by SYNC and CLR.
- LIMIT = 2**DIGIT_W: every digit is valid and ERR never asserts.
- Channels are fully independent; no cross-channel ordering.

Decomposition:
- Package b02_param_pkg holds:
  - state enum {IDLE, COLLECT};
  - MODE_MSB/MODE_LSB constants;
  - function sat_inc(value, width) for the saturating counter.
- Sub-module b02_param_chan holds one channel: FSM, shift register, BC, pulse generation and counter.
- The top level generates NCH instances and concatenates their outputs.

Test Plan (defaults NCH=2, DIGIT_W=4, LIMIT=10, CNT_W=8):
- Reset release, ch0 MODE=0, EN=1, bits 1,0,0,1 on 4 consecutive cycles -> next cycle U_REG[0]=1 for 1 cycle, DIGIT ch0 = 9, HIT_CNT ch0 = 1, ERR = 0.
- Ch0 MODE=0, bits 1,0,1,0 -> ERR[0]=1 for 1 cycle, DIGIT = 10, HIT_CNT unchanged; then bits 0,0,1,1 with MODE=1 -> ERR, DIGIT = 12; the same bits with MODE=0 -> U_REG, DIGIT = 3.
- Ch1 bits 0,1 then EN=0 for 3 cycles, then 1,1 -> a single U_REG[1] pulse, DIGIT ch1 = 7; ch0 outputs stay 0 throughout.
- Ch0 bits 1,1,1, then SYNC=1 with EN=1 and bit 0, then bits 1,0,1 -> no pulse from the first 3 bits; U_REG pulses once with DIGIT = 5.
- 255 valid digits on ch0 -> HIT_CNT = 255; 2 more -> stays 255; CLR in the same cycle as a U_REG pulse -> HIT_CNT = 0 and U_REG = 1.
- Assert reset mid-digit (after 2 bits) -> all outputs 0 immediately; a fresh 4-bit digit then completes normally.

Source files
------------

// File: rtl/b02_param_pkg.sv
// Shared types and helpers for the b02_param multi-channel serial digit recogniser.
// Latency: none (package only).
// Backpressure: none; the recogniser accepts bits whenever EN is high.
package b02_param_pkg;

    // Per-channel recogniser state: waiting for a first bit, or part-way through a digit.
    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } chan_state_t;

    // Bit-order select values for the MODE input.
    localparam logic MODE_MSB = 1'b0;
    localparam logic MODE_LSB = 1'b1;

    // Saturating increment for counters up to 32 bits wide: holds at 2**width-1.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [32:0] max_v;
        max_v = (33'd1 << width) - 33'd1;
        if ({1'b0, value} >= max_v) begin
            return value;
        end
        return value + 32'd1;
    endfunction

endpackage

// File: rtl/b02_param_chan.sv
// One recogniser channel: assembles DIGIT_W-bit digits from a gated serial stream and classifies them.
// Latency: U_REG/ERR/DIGIT/HIT_CNT update on the same edge that samples the final bit (1 cycle after input).
// Backpressure: none; a bit is consumed every cycle en=1, back-to-back digits need no gap.
module b02_param_chan
    import b02_param_pkg::*;
#(
    parameter int DIGIT_W = 4,
    parameter int LIMIT   = 10,
    parameter int CNT_W   = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               en,
    input  logic               linea,
    input  logic               mode,
    input  logic               sync,
    input  logic               clr,
    output logic               u_reg,
    output logic               err,
    output logic [DIGIT_W-1:0] digit,
    output logic [CNT_W-1:0]   hit_cnt
);

    localparam int                 BC_W    = $clog2(DIGIT_W);
    localparam logic [BC_W-1:0]    BC_LAST = BC_W'(DIGIT_W - 1);
    // One extra bit so LIMIT = 2**DIGIT_W is representable (every digit valid).
    localparam logic [DIGIT_W:0]   LIMIT_V = (DIGIT_W + 1)'(LIMIT);

    chan_state_t        state;
    chan_state_t        state_nxt;
    logic [BC_W-1:0]    bc;
    logic [BC_W-1:0]    bc_nxt;
    logic [DIGIT_W-1:0] sr;
    logic [DIGIT_W-1:0] sr_nxt;

    // A new digit starts from an empty register either from IDLE or when SYNC
    // throws away the partial digit in the same cycle as a fresh bit.
    logic               start;
    logic [BC_W-1:0]    base_bc;
    logic [DIGIT_W-1:0] base_sr;
    logic [DIGIT_W-1:0] asm_val;
    logic               done;
    logic               valid;

    // State register, bit counter and partial-digit shift register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            bc    <= '0;
            sr    <= '0;
        end else begin
            state <= state_nxt;
            bc    <= bc_nxt;
            sr    <= sr_nxt;
        end
    end

    // Next-state logic: place the incoming bit, detect completion, honour SYNC.
    always_comb begin
        state_nxt = state;
        bc_nxt    = bc;
        sr_nxt    = sr;
        done      = 1'b0;
        start     = sync || (state == IDLE);
        base_bc   = start ? '0 : bc;
        base_sr   = start ? '0 : sr;

        if (mode == MODE_LSB) begin
            asm_val = base_sr | (DIGIT_W'(linea) << base_bc);
        end else begin
            asm_val = {base_sr[DIGIT_W-2:0], linea};
        end

        if (en) begin
            // base_bc is 0 whenever start is set, so SYNC always suppresses completion.
            if (base_bc == BC_LAST) begin
                done      = 1'b1;
                state_nxt = IDLE;
                bc_nxt    = '0;
                sr_nxt    = '0;
            end else begin
                state_nxt = COLLECT;
                bc_nxt    = base_bc + BC_W'(1);
                sr_nxt    = asm_val;
            end
        end else if (sync) begin
            state_nxt = IDLE;
            bc_nxt    = '0;
            sr_nxt    = '0;
        end
    end

    assign valid = ({1'b0, asm_val} < LIMIT_V);

    // Registered completion outputs: single-cycle pulses, held digit value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            u_reg <= 1'b0;
            err   <= 1'b0;
            digit <= '0;
        end else begin
            u_reg <= done && valid;
            err   <= done && !valid;
            if (done) begin
                digit <= asm_val;
            end
        end
    end

    // Saturating valid-digit counter; CLR takes priority over a same-cycle hit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_cnt <= '0;
        end else if (clr) begin
            hit_cnt <= '0;
        end else if (done && valid) begin
            hit_cnt <= CNT_W'(sat_inc(32'(hit_cnt), CNT_W));
        end
    end

endmodule

// File: rtl/b02_param.sv
// NCH independent serial digit recognisers with packed per-channel outputs.
// Latency: 1 cycle from the final bit of a digit to U_REG/ERR/DIGIT/HIT_CNT.
// Backpressure: none; each channel consumes LINEA whenever its EN bit is high.
module b02_param
    import b02_param_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int DIGIT_W = 4,
    parameter int LIMIT   = 10,
    parameter int CNT_W   = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NCH-1:0]           EN,
    input  logic [NCH-1:0]           LINEA,
    input  logic                     MODE,
    input  logic [NCH-1:0]           SYNC,
    input  logic                     CLR,
    output logic [NCH-1:0]           U_REG,
    output logic [NCH-1:0]           ERR,
    output logic [NCH*DIGIT_W-1:0]   DIGIT,
    output logic [NCH*CNT_W-1:0]     HIT_CNT
);

    // MODE and CLR are shared; everything else is sliced per channel.
    for (genvar i = 0; i < NCH; i++) begin : g_chan
        b02_param_chan #(
            .DIGIT_W (DIGIT_W),
            .LIMIT   (LIMIT),
            .CNT_W   (CNT_W)
        ) u_chan (
            .clock   (clock),
            .reset   (reset),
            .en      (EN[i]),
            .linea   (LINEA[i]),
            .mode    (MODE),
            .sync    (SYNC[i]),
            .clr     (CLR),
            .u_reg   (U_REG[i]),
            .err     (ERR[i]),
            .digit   (DIGIT[i*DIGIT_W +: DIGIT_W]),
            .hit_cnt (HIT_CNT[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_b02_param.sv
// Self-checking bench for b02_param: digit-level reference model plus directed literal checks.
// Latency: model expects outputs one edge after the final bit.
// Backpressure: none exercised; EN gating and SYNC are driven directly.
module tb_b02_param;
    localparam int NCH     = 2;
    localparam int DIGIT_W = 4;
    localparam int LIMIT   = 10;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                   clock;
    logic                   reset;
    logic [NCH-1:0]         EN;
    logic [NCH-1:0]         LINEA;
    logic                   MODE;
    logic [NCH-1:0]         SYNC;
    logic                   CLR;
    logic [NCH-1:0]         U_REG;
    logic [NCH-1:0]         ERR;
    logic [NCH*DIGIT_W-1:0] DIGIT;
    logic [NCH*CNT_W-1:0]   HIT_CNT;

    int n_cmp = 0;
    int n_bad = 0;

    b02_param #(
        .NCH(NCH), .DIGIT_W(DIGIT_W), .LIMIT(LIMIT), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset), .EN(EN), .LINEA(LINEA), .MODE(MODE),
        .SYNC(SYNC), .CLR(CLR), .U_REG(U_REG), .ERR(ERR), .DIGIT(DIGIT),
        .HIT_CNT(HIT_CNT)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: list of accepted bits per channel ----------------
    int bitq   [NCH][DIGIT_W];
    int nbits  [NCH];
    int exp_u  [NCH];
    int exp_e  [NCH];
    int exp_d  [NCH];
    int exp_c  [NCH];

    function automatic int digit_value(input int c, input logic lsb_first);
        int v = 0;
        for (int k = 0; k < DIGIT_W; k++) begin
            if (lsb_first) v += bitq[c][k] * (2 ** k);
            else           v += bitq[c][k] * (2 ** (DIGIT_W - 1 - k));
        end
        return v;
    endfunction

    always @(posedge clock or negedge reset) begin
        for (int c = 0; c < NCH; c++) begin
            if (!reset) begin
                nbits[c] = 0; exp_u[c] = 0; exp_e[c] = 0; exp_d[c] = 0; exp_c[c] = 0;
            end else begin
                int v;
                exp_u[c] = 0;
                exp_e[c] = 0;
                if (SYNC[c]) nbits[c] = 0;
                if (EN[c]) begin
                    bitq[c][nbits[c]] = int'(LINEA[c]);
                    nbits[c]++;
                    if (nbits[c] == DIGIT_W) begin
                        v = digit_value(c, MODE);
                        exp_d[c] = v;
                        nbits[c] = 0;
                        if (v < LIMIT) begin
                            exp_u[c] = 1;
                            if (exp_c[c] < CNT_MAX) exp_c[c]++;
                        end else begin
                            exp_e[c] = 1;
                        end
                    end
                end
                if (CLR) exp_c[c] = 0;
            end
        end
    end

    // Compare every cycle on the falling edge, away from input changes and the active edge.
    always @(negedge clock) begin
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("u_reg[%0d]", c), 32'(U_REG[c]), 32'(exp_u[c]));
            check($sformatf("err[%0d]", c), 32'(ERR[c]), 32'(exp_e[c]));
            check($sformatf("digit[%0d]", c), 32'(DIGIT[c*DIGIT_W +: DIGIT_W]), 32'(exp_d[c]));
            check($sformatf("hit_cnt[%0d]", c), 32'(HIT_CNT[c*CNT_W +: CNT_W]), 32'(exp_c[c]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [NCH-1:0] en, input logic [NCH-1:0] lin,
                         input logic [NCH-1:0] sy, input logic clr_i);
        EN = en; LINEA = lin; SYNC = sy; CLR = clr_i;
        @(posedge clock);
        #1;
        EN = '0; LINEA = '0; SYNC = '0; CLR = 1'b0;
    endtask

    task automatic bitc(input int ch, input logic b);
        logic [NCH-1:0] m;
        m = '0;
        m[ch] = 1'b1;
        drive(m, b ? m : '0, '0, 1'b0);
    endtask

    // Sends seq[3] first ... seq[0] last; optional CLR alongside the final bit.
    task automatic digc(input int ch, input logic [3:0] seq, input logic clr_last);
        logic [NCH-1:0] m;
        m = '0;
        m[ch] = 1'b1;
        for (int k = 3; k >= 1; k--) drive(m, seq[k] ? m : '0, '0, 1'b0);
        drive(m, seq[0] ? m : '0, '0, clr_last);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive('0, '0, '0, 1'b0);
    endtask

    initial begin
        reset = 1'b0; EN = '0; LINEA = '0; MODE = 1'b0; SYNC = '0; CLR = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        check("rst_u", 32'(U_REG), 32'd0);
        check("rst_digit", 32'(DIGIT), 32'd0);
        check("rst_hit", 32'(HIT_CNT), 32'd0);
        idle(1);

        // MSB-first 1,0,0,1 -> 9, valid
        MODE = 1'b0;
        digc(0, 4'b1001, 1'b0);
        check("t1_u", 32'(U_REG), 32'd1);
        check("t1_err", 32'(ERR), 32'd0);
        check("t1_digit", 32'(DIGIT[3:0]), 32'd9);
        check("t1_hit", 32'(HIT_CNT[7:0]), 32'd1);
        idle(1);
        check("t1_pulse_len", 32'(U_REG), 32'd0);

        // 1,0,1,0 -> 10, invalid
        digc(0, 4'b1010, 1'b0);
        check("t2_err", 32'(ERR), 32'd1);
        check("t2_digit", 32'(DIGIT[3:0]), 32'd10);
        check("t2_hit", 32'(HIT_CNT[7:0]), 32'd1);
        idle(1);

        // 0,0,1,1 LSB-first -> 12 invalid; MSB-first -> 3 valid
        MODE = 1'b1;
        digc(0, 4'b0011, 1'b0);
        check("t3_err", 32'(ERR), 32'd1);
        check("t3_digit", 32'(DIGIT[3:0]), 32'd12);
        MODE = 1'b0;
        digc(0, 4'b0011, 1'b0);
        check("t3b_u", 32'(U_REG), 32'd1);
        check("t3b_digit", 32'(DIGIT[3:0]), 32'd3);

        // Ch1 with EN gaps: 0,1,<gap x3>,1,1 -> 7
        bitc(1, 1'b0);
        bitc(1, 1'b1);
        idle(3);
        bitc(1, 1'b1);
        bitc(1, 1'b1);
        check("t4_u", 32'(U_REG), 32'd2);
        check("t4_digit1", 32'(DIGIT[7:4]), 32'd7);
        idle(1);

        // SYNC drops 1,1,1; the SYNC-cycle bit starts 0,1,0,1 -> 5
        bitc(0, 1'b1); bitc(0, 1'b1); bitc(0, 1'b1);
        drive(2'b01, 2'b00, 2'b01, 1'b0);
        check("t5_nopulse", 32'(U_REG | ERR), 32'd0);
        bitc(0, 1'b1); bitc(0, 1'b0); bitc(0, 1'b1);
        check("t5_u", 32'(U_REG), 32'd1);
        check("t5_digit", 32'(DIGIT[3:0]), 32'd5);

        // SYNC on what would be the completing bit: digit discarded, bit restarts
        bitc(1, 1'b1); bitc(1, 1'b0); bitc(1, 1'b0);
        drive(2'b10, 2'b00, 2'b10, 1'b0);
        check("t6_nopulse", 32'(U_REG | ERR), 32'd0);
        bitc(1, 1'b0); bitc(1, 1'b1); bitc(1, 1'b1);
        check("t6_digit1", 32'(DIGIT[7:4]), 32'd3);

        // Saturation: ch0 has 3 hits, 252 more back-to-back valid digits -> 255
        for (int i = 0; i < 252; i++) digc(0, 4'(i % 10), 1'b0);
        check("t7_hit_max", 32'(HIT_CNT[7:0]), 32'd255);
        digc(0, 4'd8, 1'b0);
        digc(0, 4'd1, 1'b0);
        check("t7_hit_sat", 32'(HIT_CNT[7:0]), 32'd255);
        digc(0, 4'd2, 1'b1);
        check("t7_clr_hit", 32'(HIT_CNT[7:0]), 32'd0);
        check("t7_clr_u", 32'(U_REG), 32'd1);
        idle(1);

        // Both channels together with irregular EN, a SYNC and a CLR
        for (int i = 0; i < 48; i++) begin
            logic [5:0] iv;
            iv = 6'(i);
            MODE = 1'b0;
            drive({(i % 3) != 0, (i % 5) != 4},
                  {iv[1] ^ iv[3], iv[0] | iv[2]},
                  (i == 29) ? 2'b10 : 2'b00,
                  i == 40);
        end
        idle(2);

        // Reset mid-digit clears all outputs at once; a fresh digit then completes
        bitc(0, 1'b1); bitc(0, 1'b1);
        reset = 1'b0;
        #1;
        check("t8_rst_digit", 32'(DIGIT), 32'd0);
        check("t8_rst_hit", 32'(HIT_CNT), 32'd0);
        check("t8_rst_pulse", 32'(U_REG | ERR), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        digc(0, 4'b0110, 1'b0);
        check("t8_u", 32'(U_REG), 32'd1);
        check("t8_digit", 32'(DIGIT[3:0]), 32'd6);
        check("t8_hit", 32'(HIT_CNT[7:0]), 32'd1);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
